disp_line_buffer: RTL and testbench

Storage responder for the left/right disparity line buffers read by the left-right consistency check in post-processing. It accepts the left and right disparity streams from the aggregation stage and stages each in a 4-entry skid FIFO. It asserts `valid_final_L`/`valid_final_R` while data is staged. It commits staged words to per-side line RAMs when the checker's `wr_en`/`wr_addr_*` command arrives, and returns `q_L`/`q_R` for the checker's `rd_en`/`rd_addr_*` with one-cycle latency.

---
 rtl/disp_line_buffer.sv | 136 +++++++++++++
 tb/tb_disp_line_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_line_buffer.sv
// Left/right disparity line buffer: per-side 4-entry skid FIFOs feeding per-side line RAMs.
// Optional macro DLB_FWD_EN selects write-first same-address read/commit behaviour (default read-first).
module disp_line_buffer #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [10:0]       width,
    input  logic              din_valid_L,
    input  logic              din_valid_R,
    input  logic [DWIDTH-1:0] din_L,
    input  logic [DWIDTH-1:0] din_R,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr_L,
    input  logic [AWIDTH-1:0] wr_addr_R,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr_L,
    input  logic [AWIDTH-1:0] rd_addr_R,
    output logic [DWIDTH-1:0] q_L,
    output logic [DWIDTH-1:0] q_R,
    output logic              valid_final_L,
    output logic              valid_final_R,
    output logic              line_done,
    output logic [1:0]        err
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [1:0]        push;
    logic [1:0]        nonempty;
    logic [1:0]        ovf;
    logic              commit;
    logic              underflow;
    logic [DWIDTH-1:0] din_s   [2];
    logic [DWIDTH-1:0] head    [2];
    logic [DWIDTH-1:0] q_s     [2];
    logic [AWIDTH-1:0] wr_addr [2];
    logic [AWIDTH-1:0] rd_addr [2];

    assign push       = {din_valid_R, din_valid_L} & {2{clken}};
    assign din_s[0]   = din_L;
    assign din_s[1]   = din_R;
    assign wr_addr[0] = wr_addr_L;
    assign wr_addr[1] = wr_addr_R;
    assign rd_addr[0] = rd_addr_L;
    assign rd_addr[1] = rd_addr_R;

    // Both sides commit together so the L/R RAM lines stay pixel-aligned.
    assign commit    = wr_en & clken & nonempty[0] & nonempty[1];
    assign underflow = wr_en & clken & ~(nonempty[0] & nonempty[1]);

    for (genvar s = 0; s < 2; s++) begin : g_side
        logic [DWIDTH-1:0] mem [4];
        logic [DWIDTH-1:0] ram [DEPTH];
        logic [DWIDTH-1:0] rd_word;
        logic [1:0]        wp;
        logic [1:0]        rp;
        logic [2:0]        cnt;
        logic              full;
        logic              accept;

        assign full        = (cnt == 3'd4);
        // A full FIFO still takes a word when the head leaves in the same cycle.
        assign accept      = push[s] & (~full | commit);
        assign ovf[s]      = push[s] & full & ~commit;
        assign nonempty[s] = (cnt != 3'd0);
        assign head[s]     = mem[rp];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp  <= 2'd0;
                rp  <= 2'd0;
                cnt <= 3'd0;
            end else begin
                if (accept) wp <= wp + 2'd1;
                if (commit) rp <= rp + 2'd1;
                case ({accept, commit})
                    2'b10:   cnt <= cnt + 3'd1;
                    2'b01:   cnt <= cnt - 3'd1;
                    default: cnt <= cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (accept) mem[wp] <= din_s[s];
        end

        always_ff @(posedge clk) begin
            if (commit) ram[wr_addr[s]] <= head[s];
        end

`ifdef DLB_FWD_EN
        assign rd_word = (commit && (wr_addr[s] == rd_addr[s])) ? head[s] : ram[rd_addr[s]];
`else
        assign rd_word = ram[rd_addr[s]];
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) q_s[s] <= '0;
            else if (clken & rd_en) q_s[s] <= rd_word;
        end
    end

    assign q_L           = q_s[0];
    assign q_R           = q_s[1];
    assign valid_final_L = nonempty[0];
    assign valid_final_R = nonempty[1];

    logic [10:0] line_cnt;
    logic [10:0] last_idx;

    // A zero width is treated as a one-pixel line.
    assign last_idx = (width == 11'd0) ? 11'd0 : width - 11'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt  <= 11'd0;
            line_done <= 1'b0;
            err       <= 2'b00;
        end else if (clken) begin
            line_done <= 1'b0;
            if (commit) begin
                if (line_cnt == last_idx) begin
                    line_cnt  <= 11'd0;
                    line_done <= 1'b1;
                end else begin
                    line_cnt <= line_cnt + 11'd1;
                end
            end
            if (underflow) err[1] <= 1'b1;
            if (|ovf)      err[0] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_disp_line_buffer.sv
// Self-checking bench for disp_line_buffer: vector table plus hand sequences, read data via scoreboard.
module tb_disp_line_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic [10:0] width;
    logic        din_valid_L, din_valid_R;
    logic [15:0] din_L, din_R;
    logic        wr_en;
    logic [10:0] wr_addr_L, wr_addr_R;
    logic        rd_en;
    logic [10:0] rd_addr_L, rd_addr_R;
    logic [15:0] q_L, q_R;
    logic        valid_final_L, valid_final_R;
    logic        line_done;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb [$];

    typedef struct {
        logic        vl;
        logic [15:0] dl;
        logic        vr;
        logic [15:0] dr;
        logic        we;
        logic [10:0] wal;
        logic [10:0] war;
        logic        re;
        logic [10:0] ral;
        logic [10:0] rar;
        logic [15:0] eql;
        logic [15:0] eqr;
        logic        evl;
        logic        evr;
        logic [1:0]  eerr;
        logic        edone;
    } vec_t;

    vec_t tbl [10];

    disp_line_buffer #(.DWIDTH(16), .AWIDTH(11)) dut (
        .clk(clk), .rst(rst), .clken(clken), .width(width),
        .din_valid_L(din_valid_L), .din_valid_R(din_valid_R),
        .din_L(din_L), .din_R(din_R),
        .wr_en(wr_en), .wr_addr_L(wr_addr_L), .wr_addr_R(wr_addr_R),
        .rd_en(rd_en), .rd_addr_L(rd_addr_L), .rd_addr_R(rd_addr_R),
        .q_L(q_L), .q_R(q_R),
        .valid_final_L(valid_final_L), .valid_final_R(valid_final_R),
        .line_done(line_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_st(input string nm, input logic evl, input logic evr,
                          input logic [1:0] eerr, input logic edone);
        chk({nm, " valid_final_L"}, 32'(valid_final_L), 32'(evl));
        chk({nm, " valid_final_R"}, 32'(valid_final_R), 32'(evr));
        chk({nm, " err"},           32'(err),           32'(eerr));
        chk({nm, " line_done"},     32'(line_done),     32'(edone));
    endtask

    // One clock of stimulus; expected read data enters the scoreboard when the read is issued.
    task automatic cyc(input logic vl, input logic [15:0] dl, input logic vr, input logic [15:0] dr,
                       input logic we, input logic [10:0] wal, input logic [10:0] war,
                       input logic re, input logic [10:0] ral, input logic [10:0] rar,
                       input logic [15:0] eql, input logic [15:0] eqr);
        logic [31:0] e;
        din_valid_L = vl; din_L = dl; din_valid_R = vr; din_R = dr;
        wr_en = we; wr_addr_L = wal; wr_addr_R = war;
        rd_en = re; rd_addr_L = ral; rd_addr_R = rar;
        if (re && clken) sb.push_back({eql, eqr});
        @(posedge clk);
        #1;
        din_valid_L = 1'b0; din_valid_R = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q_L", 32'(q_L), 32'(e[31:16]));
            chk("q_R", 32'(q_R), 32'(e[15:0]));
        end
    endtask

    task automatic push2(input logic vl, input logic [15:0] dl, input logic vr, input logic [15:0] dr);
        cyc(vl, dl, vr, dr, 1'b0, 11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 16'h0, 16'h0);
    endtask

    task automatic commit(input logic [10:0] wal, input logic [10:0] war);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, wal, war, 1'b0, 11'd0, 11'd0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [10:0] ral, input logic [10:0] rar, input logic [15:0] eql, input logic [15:0] eqr);
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 11'd0, 11'd0, 1'b1, ral, rar, eql, eqr);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clken = 1'b1; width = 11'd4;
        din_valid_L = 1'b0; din_valid_R = 1'b0; din_L = 16'h0; din_R = 16'h0;
        wr_en = 1'b0; wr_addr_L = 11'd0; wr_addr_R = 11'd0;
        rd_en = 1'b0; rd_addr_L = 11'd0; rd_addr_R = 11'd0;
        #7;
        chk_st("reset", 1'b0, 1'b0, 2'b00, 1'b0);
        chk("reset q_L", 32'(q_L), 32'h0);
        chk("reset q_R", 32'(q_R), 32'h0);
        #1 rst = 1'b0;

        // Commit/read and a width-4 line: vl dl vr dr we wal war re ral rar eql eqr | evl evr err done
        tbl[0] = '{1'b1, 16'h0005, 1'b1, 16'h0007, 1'b0, 11'd0, 11'd0, 1'b0, 11'd0,  11'd0,  16'h0,    16'h0,    1'b1, 1'b1, 2'b00, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 11'd3, 11'd4, 1'b0, 11'd0,  11'd0,  16'h0,    16'h0,    1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 11'd0, 11'd0, 1'b1, 11'd3,  11'd4,  16'h0005, 16'h0007, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[3] = '{1'b1, 16'h000A, 1'b1, 16'h000B, 1'b0, 11'd0, 11'd0, 1'b0, 11'd0,  11'd0,  16'h0,    16'h0,    1'b1, 1'b1, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 16'h000C, 1'b1, 16'h000D, 1'b1, 11'd5, 11'd6, 1'b0, 11'd0,  11'd0,  16'h0,    16'h0,    1'b1, 1'b1, 2'b00, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 11'd7, 11'd8, 1'b0, 11'd0,  11'd0,  16'h0,    16'h0,    1'b0, 1'b0, 2'b00, 1'b0};
        tbl[6] = '{1'b1, 16'h000E, 1'b1, 16'h000F, 1'b0, 11'd0, 11'd0, 1'b0, 11'd0,  11'd0,  16'h0,    16'h0,    1'b1, 1'b1, 2'b00, 1'b0};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 11'd9, 11'd10, 1'b0, 11'd0, 11'd0,  16'h0,    16'h0,    1'b0, 1'b0, 2'b00, 1'b1};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 11'd0, 11'd0, 1'b1, 11'd5,  11'd6,  16'h000A, 16'h000B, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[9] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 11'd0, 11'd0, 1'b1, 11'd9,  11'd10, 16'h000E, 16'h000F, 1'b0, 1'b0, 2'b00, 1'b0};
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].vl, tbl[i].dl, tbl[i].vr, tbl[i].dr, tbl[i].we, tbl[i].wal, tbl[i].war,
                tbl[i].re, tbl[i].ral, tbl[i].rar, tbl[i].eql, tbl[i].eqr);
            chk_st($sformatf("vec%0d", i), tbl[i].evl, tbl[i].evr, tbl[i].eerr, tbl[i].edone);
        end
        rd(11'd7, 11'd8, 16'h000C, 16'h000D);

        // Asynchronous reset in mid-cycle with a staged word and nonzero q
        push2(1'b1, 16'h0044, 1'b0, 16'h0);
        #2 rst = 1'b1;
        #1;
        chk_st("async rst", 1'b0, 1'b0, 2'b00, 1'b0);
        chk("async rst q_L", 32'(q_L), 32'h0);
        chk("async rst q_R", 32'(q_R), 32'h0);
        rst = 1'b0;
        push2(1'b1, 16'h0012, 1'b0, 16'h0);
        chk_st("post-rst push", 1'b1, 1'b0, 2'b00, 1'b0);

        // Commit with R empty: no pop, L head retained, underflow flagged
        commit(11'd30, 11'd31);
        chk_st("underflow", 1'b1, 1'b0, 2'b10, 1'b0);
        push2(1'b0, 16'h0, 1'b1, 16'h0033);
        commit(11'd20, 11'd21);
        chk_st("after underflow commit", 1'b0, 1'b0, 2'b10, 1'b0);
        rd(11'd20, 11'd21, 16'h0012, 16'h0033);

        // clken low ignores pushes and commits
        do_reset();
        clken = 1'b0;
        cyc(1'b1, 16'h0077, 1'b1, 16'h0078, 1'b1, 11'd60, 11'd60, 1'b0, 11'd0, 11'd0, 16'h0, 16'h0);
        chk_st("clken=0", 1'b0, 1'b0, 2'b00, 1'b0);
        clken = 1'b1;

        // FIFO limits: 5th push dropped; push+pop on full keeps count at 4
        push2(1'b1, 16'h0101, 1'b1, 16'h0201);
        for (int i = 2; i <= 4; i++) push2(1'b1, 16'h0100 + 16'(i), 1'b0, 16'h0);
        chk_st("four pushes", 1'b1, 1'b1, 2'b00, 1'b0);
        push2(1'b1, 16'h0105, 1'b0, 16'h0);
        chk_st("overflow", 1'b1, 1'b1, 2'b01, 1'b0);
        cyc(1'b1, 16'h0106, 1'b0, 16'h0, 1'b1, 11'd39, 11'd39, 1'b0, 11'd0, 11'd0, 16'h0, 16'h0);
        chk_st("push+pop full", 1'b1, 1'b0, 2'b01, 1'b0);
        for (int i = 2; i <= 5; i++) push2(1'b0, 16'h0, 1'b1, 16'h0200 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            commit(11'd40 + 11'(i), 11'd40 + 11'(i));
            chk("drain valid_final_L", 32'(valid_final_L), (i < 3) ? 32'd1 : 32'd0);
        end
        chk("drain err", 32'(err), 32'h1);
        rd(11'd39, 11'd39, 16'h0101, 16'h0201);
        rd(11'd40, 11'd40, 16'h0102, 16'h0202);
        rd(11'd41, 11'd41, 16'h0103, 16'h0203);
        rd(11'd42, 11'd42, 16'h0104, 16'h0204);
        rd(11'd43, 11'd43, 16'h0106, 16'h0205);

        // width = 0 pulses line_done after every commit
        do_reset();
        width = 11'd0;
        push2(1'b1, 16'h0001, 1'b1, 16'h0002);
        chk_st("w0 push1", 1'b1, 1'b1, 2'b00, 1'b0);
        commit(11'd50, 11'd50);
        chk_st("w0 commit1", 1'b0, 1'b0, 2'b00, 1'b1);
        push2(1'b1, 16'h0003, 1'b1, 16'h0004);
        chk_st("w0 push2", 1'b1, 1'b1, 2'b00, 1'b0);
        commit(11'd51, 11'd51);
        chk_st("w0 commit2", 1'b0, 1'b0, 2'b00, 1'b1);
        push2(1'b0, 16'h0, 1'b0, 16'h0);
        chk_st("w0 idle", 1'b0, 1'b0, 2'b00, 1'b0);

        // Same-address read during commit
        do_reset();
        width = 11'd4;
        push2(1'b1, 16'h0001, 1'b1, 16'h0000);
        commit(11'd2, 11'd2);
        push2(1'b1, 16'h0009, 1'b1, 16'h0005);
`ifdef DLB_FWD_EN
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 11'd2, 11'd2, 1'b1, 11'd2, 11'd2, 16'h0009, 16'h0005);
`else
        cyc(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 11'd2, 11'd2, 1'b1, 11'd2, 11'd2, 16'h0001, 16'h0000);
`endif
        rd(11'd2, 11'd2, 16'h0009, 16'h0005);
        push2(1'b0, 16'h0, 1'b0, 16'h0);
        chk("q_L hold", 32'(q_L), 32'h0009);
        chk("q_R hold", 32'(q_R), 32'h0005);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
